// File: rtl/ks_string_if.sv
// Handshake/data bundle between the note logic, the string controller and its delay line.
interface ks_string_if #(parameter int B = 8);
   logic         sample_en;
   logic         pluck;
   logic [15:0]  seed;
   logic [15:0]  dur;
   logic [B-1:0] dl_out;
   logic [B-1:0] dl_in;
   logic [B-1:0] audio;
   logic         busy;
   logic         done;

   modport master (output sample_en, pluck, seed, dur, dl_out,
                   input  dl_in, audio, busy, done);
   modport slave  (input  sample_en, pluck, seed, dur, dl_out,
                   output dl_in, audio, busy, done);
endinterface

// File: rtl/ks_string_ctrl.sv
// Karplus-Strong string sequencer: noise burst of L samples into the delay line,
// then a two-tap averaging feedback ring for dur samples, then zero flush.
module ks_string_ctrl #(
   parameter int L = 4,
   parameter int B = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   ks_string_if.slave  s
);
   localparam int          CW         = $clog2(L + 1);
   localparam logic [15:0] LFSR_INIT  = 16'hACE1;
   localparam logic [CW-1:0] BURST_LAST = CW'(L - 1);

   typedef enum logic [1:0] {IDLE, BURST, RING} state_t;

   state_t        state, state_nx;
   logic [15:0]   lfsr, dur_q, ring_cnt;
   logic [CW-1:0] burst_cnt;
   logic [B-1:0]  prev, dl_in_q, audio_q;
   logic          done_q;
   logic          accept, to_idle;
   logic [B:0]    sum;
   logic [15:0]   lfsr_nx;

   assign sum     = {1'b0, s.dl_out} + {1'b0, prev};
   assign lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE:  if (s.pluck) begin
                   accept   = 1'b1;
                   state_nx = BURST;
                end
         BURST: if (s.sample_en && burst_cnt == BURST_LAST)
                   state_nx = (dur_q == 16'd0) ? IDLE : RING;
         RING:  if (s.sample_en && ring_cnt == dur_q - 16'd1)
                   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      to_idle = (state != IDLE) && (state_nx == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lfsr      <= LFSR_INIT;
         dur_q     <= '0;
         ring_cnt  <= '0;
         burst_cnt <= '0;
         prev      <= '0;
         dl_in_q   <= '0;
         audio_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= to_idle;
         case (state)
            IDLE: begin
               dl_in_q <= '0;
               if (accept) begin
                  dur_q     <= s.dur;
                  lfsr      <= (s.seed == 16'd0) ? LFSR_INIT : s.seed;
                  burst_cnt <= '0;
                  ring_cnt  <= '0;
                  prev      <= '0;
               end else if (s.sample_en) begin
                  audio_q <= '0;
               end
            end
            BURST: if (s.sample_en) begin
               // The edge that returns to IDLE starts the zero flush instead.
               dl_in_q   <= to_idle ? '0 : lfsr[B-1:0];
               lfsr      <= lfsr_nx;
               audio_q   <= s.dl_out;
               burst_cnt <= burst_cnt + CW'(1);
            end
            RING: if (s.sample_en) begin
               dl_in_q  <= to_idle ? '0 : sum[B:1];
               prev     <= s.dl_out;
               audio_q  <= s.dl_out;
               ring_cnt <= ring_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign s.dl_in = dl_in_q;
   assign s.audio = audio_q;
   assign s.busy  = (state != IDLE);
   assign s.done  = done_q;
endmodule
